// File: rtl/mips_defs.sv
// Shared MIPS decode constants and the per-instruction hazard summary
// used by the stall/flush controller.
package mips_defs;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MTHI  = 6'b010001;
   localparam logic [5:0] FN_MFLO  = 6'b010010;
   localparam logic [5:0] FN_MTLO  = 6'b010011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   typedef logic [1:0] tval_t;

   localparam tval_t TUSE_0    = 2'd0;
   localparam tval_t TUSE_1    = 2'd1;
   localparam tval_t TUSE_2    = 2'd2;
   localparam tval_t TUSE_NONE = 2'd3;
   localparam tval_t TNEW_0    = 2'd0;
   localparam tval_t TNEW_1    = 2'd1;
   localparam tval_t TNEW_2    = 2'd2;

   typedef struct packed {
      logic  is_lw;
      logic  is_md;     // mult/multu/div/divu
      logic  is_div;    // div/divu
      logic  is_mfmt;   // mfhi/mflo/mthi/mtlo
      logic  is_br;     // beq/jr
      tval_t tuse_rs;
      tval_t tuse_rt;
      tval_t tnew;      // as seen from the E stage
   } instr_info_t;

   // A source is hazardous when its producer is still further from done than the consumer can wait.
   function automatic logic reg_hazard(input logic [4:0] src, input logic [4:0] wa,
                                       input tval_t tuse, input tval_t tnew);
      return (src == wa) && (wa != 5'd0) && (tuse < tnew);
   endfunction

endpackage

// File: rtl/instr_class.sv
// Combinational decode of one instruction word into its hazard summary
// (class flags plus Tuse for rs/rt and Tnew at the E stage).
module instr_class
   import mips_defs::*;
(
   input  logic [31:0] instr,
   output instr_info_t info
);

   logic [5:0] op;
   logic [5:0] fn;
   logic       unused_bits;

   assign op          = instr[31:26];
   assign fn          = instr[5:0];
   assign unused_bits = ^instr[25:6];

   always_comb begin
      info         = '0;
      info.tuse_rs = TUSE_NONE;
      info.tuse_rt = TUSE_NONE;
      info.tnew    = TNEW_0;
      unique case (op)
         OP_RTYPE: begin
            unique case (fn)
               FN_ADDU, FN_SUBU: begin
                  info.tuse_rs = TUSE_1;
                  info.tuse_rt = TUSE_1;
                  info.tnew    = TNEW_1;
               end
               FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                  info.is_md   = 1'b1;
                  info.is_div  = (fn == FN_DIV) || (fn == FN_DIVU);
                  info.tuse_rs = TUSE_1;
                  info.tuse_rt = TUSE_1;
               end
               FN_MFHI, FN_MFLO: begin
                  info.is_mfmt = 1'b1;
                  info.tnew    = TNEW_1;
               end
               FN_MTHI, FN_MTLO: begin
                  info.is_mfmt = 1'b1;
                  info.tuse_rs = TUSE_1;
               end
               FN_JR: begin
                  info.is_br   = 1'b1;
                  info.tuse_rs = TUSE_0;
               end
               default: ;
            endcase
         end
         OP_LW: begin
            info.is_lw   = 1'b1;
            info.tuse_rs = TUSE_1;
            info.tnew    = TNEW_2;
         end
         OP_SW: begin
            info.tuse_rs = TUSE_1;
            info.tuse_rt = TUSE_2;
         end
         OP_BEQ: begin
            info.is_br   = 1'b1;
            info.tuse_rs = TUSE_0;
            info.tuse_rt = TUSE_0;
         end
         OP_ORI: begin
            info.tuse_rs = TUSE_1;
            info.tnew    = TNEW_1;
         end
         OP_LUI: info.tnew = TNEW_1;
         OP_JAL: ;   // writes $31 from the PC; nothing left to wait for past E
         default: ;
      endcase
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline: load-use and branch-use
// hazard detection plus the mult/div busy counter.
module hazard_ctrl
   import mips_defs::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instrD,
   input  logic [31:0] instrE,
   input  logic [31:0] instrM,
   input  logic [4:0]  waE,
   input  logic [4:0]  waM,
   output logic        stallF,
   output logic        stallD,
   output logic        Eclr,
   output logic        mdStart,
   output logic        mdBusy
);

   instr_info_t      d_info;
   instr_info_t      e_info;
   instr_info_t      m_info;
   logic [4:0]       rs_d;
   logic [4:0]       rt_d;
   tval_t            tnew_m;
   logic             data_stall;
   logic             md_stall;
   logic             stall;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             unused_info;

   instr_class u_class_d (.instr(instrD), .info(d_info));
   instr_class u_class_e (.instr(instrE), .info(e_info));
   instr_class u_class_m (.instr(instrM), .info(m_info));

   assign rs_d        = instrD[25:21];
   assign rt_d        = instrD[20:16];
   // Only a load still has a result pending once it reaches M.
   assign tnew_m      = m_info.is_lw ? TNEW_1 : TNEW_0;
   assign unused_info = ^{d_info, e_info, m_info};

   assign mdStart = e_info.is_md;
   assign mdBusy  = (cnt_q != '0);

   always_comb begin
      data_stall = reg_hazard(rs_d, waE, d_info.tuse_rs, e_info.tnew)
                 | reg_hazard(rt_d, waE, d_info.tuse_rt, e_info.tnew)
                 | reg_hazard(rs_d, waM, d_info.tuse_rs, tnew_m)
                 | reg_hazard(rt_d, waM, d_info.tuse_rt, tnew_m);
      md_stall   = (d_info.is_md | d_info.is_mfmt) & (mdBusy | mdStart);
      stall      = data_stall | md_stall;
   end

   assign stallF = stall;
   assign stallD = stall;
   assign Eclr   = stall;

   // A fresh start reloads the counter even if a previous operation is still counting.
   always_comb begin
      cnt_d = cnt_q;
      if (mdStart) begin
         cnt_d = e_info.is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
